fir_coef_loader: RTL and testbench
==================================

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter WIDTH_B, default 32: coefficient width in bits, matching the b_in width of the filter step blocks.
REQ-002 Parameter TAPS, default 8: number of filter taps served; TAPS >= 2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ena  input  1  enable; while low, all state holds, s_ready=0, done/err do not pulse.
REQ-006 start  input  1  request to begin a new coefficient load.
REQ-007 s_valid  input  1  coefficient beat valid.
REQ-008 s_data  input  WIDTH_B  signed coefficient beat.
REQ-009 s_last  input  1  marks the final beat of a load.
REQ-010 s_ready  output  1  loader accepts a beat this cycle.
REQ-011 coef_flat  output  TAPS*WIDTH_B  active coefficients; tap k occupies bits [k*WIDTH_B +: WIDTH_B]; this bus drives b_in of step k.
REQ-012 busy  output  1  high in LOAD and COMMIT.
REQ-013 done  output  1  one-cycle pulse on successful commit.
REQ-014 err  output  1  one-cycle pulse on an aborted load.

Function
REQ-015 The loader SHALL keep a shadow bank and an active bank, each TAPS x WIDTH_B; coef_flat SHALL be driven only by registered active-bank storage.
REQ-016 The FSM SHALL have the states IDLE, LOAD and COMMIT; all transitions SHALL require ena=1.
REQ-017 IDLE: start=1 SHALL set the beat counter to 0 and move to LOAD; s_ready=0 in IDLE.
REQ-018 LOAD: s_ready SHALL be 1; a beat is accepted when s_valid and s_ready are both 1.
REQ-019 Each accepted beat SHALL write s_data to shadow[count], then increment count.
REQ-020 A beat accepted with count=TAPS-1 and s_last=1 SHALL move the FSM to COMMIT.
REQ-021 A beat accepted with count=TAPS-1 and s_last=0 (overrun), or with s_last=1 and count<TAPS-1 (underrun), SHALL pulse err in the next cycle and return the FSM to IDLE.
REQ-022 On an aborted load, the active bank SHALL remain unchanged.
REQ-023 COMMIT SHALL last exactly one cycle: it copies the whole shadow bank to the active bank, pulses done in the following cycle, and returns the FSM to IDLE.
REQ-024 coef_flat SHALL change atomically: all taps update on the same edge, and no tap ever carries a partially loaded set.
REQ-025 Latency: coef_flat SHALL reflect the new set 2 cycles after the last beat is accepted (ena held high), coincident with done.
REQ-026 start while in LOAD or COMMIT SHALL be ignored.
REQ-027 start and the first beat SHALL NOT be accepted in the same cycle; the first acceptable beat is the cycle after start.
REQ-028 s_valid=0 cycles in LOAD SHALL be idle and SHALL NOT count.
REQ-029 ena low mid-load SHALL freeze count, the shadow bank and the state; the load resumes when ena returns high.
REQ-030 The counter SHALL be ceil(log2(TAPS)) bits wide and SHALL never wrap; overrun is handled per REQ-021.
REQ-031 s_data SHALL be stored bit-exact, with no sign extension or truncation.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, count 0, both banks 0, coef_flat 0, s_ready 0, busy 0, done 0, err 0.
REQ-033 Reset asserted mid-load SHALL discard the partial load; no done or err pulse SHALL follow reset release.
REQ-034 After rst deasserts, the loader SHALL accept start on the first rising edge.

Verification (TAPS=4, WIDTH_B=18)
REQ-035 start, then beats 1,-2,3,-4 back-to-back with s_last on the 4th -> done pulses 2 cycles after the 4th beat, coef_flat = {-4,3,-2,1} (tap3..tap0), err=0.
REQ-036 Load 5,6,7,8; then start, beats 9,10 with s_last on 10 -> err pulses one cycle later, coef_flat stays {8,7,6,5}, no done pulse.
REQ-037 start, 4 beats with s_last=0 on the 4th -> err pulse, state IDLE, the next start is accepted normally.
REQ-038 start, beats 1,2, ena=0 for 5 cycles (s_valid held high), then ena=1 and beats 3,4(last) -> done pulses, coef_flat={4,3,2,1}, no extra beats captured.
REQ-039 Load a full set, then start, beats 7,7, assert rst asynchronously between clock edges -> coef_flat=0 before the next edge, busy=0, no done or err pulse after release.
REQ-040 Pulse start during LOAD, and insert gaps with s_valid=0 -> count unaffected, commit occurs only after the 4th accepted beat.

Source files
------------

// File: rtl/fir_coef_loader_if.sv
// Coefficient beat stream: valid/ready handshake carrying signed
// coefficient beats, with a last marker on the final beat of a load.
interface fir_coef_loader_if #(
    parameter int WIDTH_B = 32
);
    logic               s_valid;
    logic [WIDTH_B-1:0] s_data;
    logic               s_last;
    logic               s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader. Beats fill a shadow bank; a
// complete, correctly terminated load is copied to the active bank in a
// single edge, so the filter never sees a partially loaded set.
module fir_coef_loader #(
    parameter int WIDTH_B = 32,
    parameter int TAPS    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    start,
    fir_coef_loader_if.slave        s,
    output logic [TAPS*WIDTH_B-1:0] coef_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int unsigned    NT       = TAPS;
    localparam int             CW       = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CW-1:0]             count;
    logic [WIDTH_B-1:0]        shadow [TAPS];
    logic [TAPS*WIDTH_B-1:0]   active;

    logic                      ready;
    logic                      load_start;
    logic                      accept;
    logic                      abort;
    logic                      do_commit;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; every transition is qualified by ena.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        load_start = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && start) begin
                    load_start = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy  = 1'b1;
                ready = ena;
                if (ena && s.s_valid) begin
                    accept = 1'b1;
                    if (count == LAST_IDX) begin
                        if (s.s_last) begin
                            state_next = COMMIT;
                        end else begin
                            abort      = 1'b1;
                            state_next = IDLE;
                        end
                    end else if (s.s_last) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                busy = 1'b1;
                if (ena) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s.s_ready = ready;

    // Beat counter and status pulses; the counter stops at the last index
    // so it can never wrap, overrun being caught by the FSM instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= do_commit;
            err  <= abort;
            if (load_start) begin
                count <= '0;
            end else if (accept && (count != LAST_IDX)) begin
                count <= count + CW'(1);
            end
        end
    end

    // Shadow bank: accepted beats are stored bit-exact at the current index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NT; k++) begin
                shadow[k] <= '0;
            end
        end else if (accept) begin
            shadow[count] <= s.s_data;
        end
    end

    // Active bank: whole-set copy on commit so all taps change on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= '0;
        end else if (do_commit) begin
            for (int unsigned k = 0; k < NT; k++) begin
                active[k*WIDTH_B +: WIDTH_B] <= shadow[k];
            end
        end
    end

    assign coef_flat = active;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader (TAPS=4, WIDTH_B=18) with a
// scoreboard queue of expected coefficient sets popped on each done pulse.
module tb_fir_coef_loader;
    localparam int W = 18;
    localparam int T = 4;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          start;
    logic [T*W-1:0] coef_flat;
    logic          busy;
    logic          done;
    logic          err;

    int            checks   = 0;
    int            failures = 0;
    int            err_cnt  = 0;
    int            done_cnt = 0;
    int            pushes   = 0;
    logic [T*W-1:0] exp_q [$];
    logic [T*W-1:0] exp_v;

    fir_coef_loader_if #(.WIDTH_B(W)) bus ();

    fir_coef_loader #(
        .WIDTH_B (W),
        .TAPS    (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .s         (bus),
        .coef_flat (coef_flat),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [T*W-1:0] pk(input int t0, input int t1, input int t2, input int t3);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        a = W'(t0);
        b = W'(t1);
        c = W'(t2);
        d = W'(t3);
        return {d, c, b, a};
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [T*W-1:0] obs, input logic [T*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_load(input logic [T*W-1:0] v);
        exp_q.push_back(v);
        pushes++;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        check1({tag, "_idle_ready"}, bus.s_ready, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input string tag, input int data, input logic last);
        bit got;
        got = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = W'(data);
        bus.s_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                got = 1'b1;
                break;
            end
        end
        check1({tag, "_ready_wait"}, got, 1'b1);
        if (got) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check1({tag, "_commit_busy"}, busy, 1'b1);
        check1({tag, "_commit_nodone"}, done, 1'b0);
        check1({tag, "_commit_ready"}, bus.s_ready, 1'b0);
        @(negedge clk);
        check1({tag, "_done"}, done, 1'b1);
        check1({tag, "_noerr"}, err, 1'b0);
        check1({tag, "_idle_busy"}, busy, 1'b0);
        tick();
    endtask

    task automatic expect_err(input string tag);
        @(negedge clk);
        check1({tag, "_err"}, err, 1'b1);
        check1({tag, "_nodone"}, done, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        @(negedge clk);
        check1({tag, "_err_single"}, err, 1'b0);
        tick();
    endtask

    // Scoreboard: every done pulse must match the oldest pending load.
    always @(negedge clk) begin
        if (err) err_cnt++;
        if (done) begin
            done_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_done observed=%0d pending expected=>0 pending", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checkv("done_coef", coef_flat, exp_v);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        ena         = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;

        // Reset state
        @(negedge clk);
        checkv("rst_coef", coef_flat, '0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_ready", bus.s_ready, 1'b0);
        tick();
        rst = 1'b0;

        // Basic load, start on the first edge after reset release
        expect_load(pk(1, -2, 3, -4));
        do_start("t1");
        send("t1b0", 1, 1'b0);
        send("t1b1", -2, 1'b0);
        send("t1b2", 3, 1'b0);
        send("t1b3", -4, 1'b1);
        expect_done("t1");
        checkv("t1_coef", coef_flat, pk(1, -2, 3, -4));

        // Full load then underrun abort
        expect_load(pk(5, 6, 7, 8));
        do_start("t2a");
        send("t2a0", 5, 1'b0);
        send("t2a1", 6, 1'b0);
        send("t2a2", 7, 1'b0);
        send("t2a3", 8, 1'b1);
        expect_done("t2a");
        do_start("t2b");
        send("t2b0", 9, 1'b0);
        send("t2b1", 10, 1'b1);
        expect_err("t2_underrun");
        checkv("t2_coef_kept", coef_flat, pk(5, 6, 7, 8));

        // Overrun abort, then a normal load is accepted
        do_start("t3a");
        send("t3a0", 1, 1'b0);
        send("t3a1", 2, 1'b0);
        send("t3a2", 3, 1'b0);
        send("t3a3", 4, 1'b0);
        expect_err("t3_overrun");
        checkv("t3_coef_kept", coef_flat, pk(5, 6, 7, 8));
        expect_load(pk(11, 12, 13, 14));
        do_start("t3b");
        send("t3b0", 11, 1'b0);
        send("t3b1", 12, 1'b0);
        send("t3b2", 13, 1'b0);
        send("t3b3", 14, 1'b1);
        expect_done("t3b");

        // ena low mid-load with s_valid held high
        expect_load(pk(1, 2, 3, 4));
        do_start("t4");
        send("t4b0", 1, 1'b0);
        send("t4b1", 2, 1'b0);
        ena         = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = W'(99);
        repeat (5) begin
            @(negedge clk);
            check1("t4_frz_ready", bus.s_ready, 1'b0);
            check1("t4_frz_busy", busy, 1'b1);
        end
        tick();
        ena         = 1'b1;
        bus.s_valid = 1'b0;
        send("t4b2", 3, 1'b0);
        send("t4b3", 4, 1'b1);
        expect_done("t4");

        // Gaps and stray start pulses during LOAD
        expect_load(pk(21, 22, 23, 24));
        do_start("t5");
        send("t5b0", 21, 1'b0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send("t5b1", 22, 1'b0);
        tick();
        start = 1'b1;
        send("t5b2", 23, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check1("t5_still_busy", busy, 1'b1);
        tick();
        send("t5b3", 24, 1'b1);
        expect_done("t5");

        // Asynchronous reset between edges during a partial load
        do_start("t6");
        send("t6b0", 7, 1'b0);
        send("t6b1", 7, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkv("t6_async_coef", coef_flat, '0);
        check1("t6_async_busy", busy, 1'b0);
        check1("t6_async_ready", bus.s_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check1("t6_quiet_done", done, 1'b0);
            check1("t6_quiet_err", err, 1'b0);
        end
        tick();

        // Extreme values stored bit-exact
        expect_load(pk(131071, -131072, -1, 0));
        do_start("t7");
        send("t7b0", 131071, 1'b0);
        send("t7b1", -131072, 1'b0);
        send("t7b2", -1, 1'b0);
        send("t7b3", 0, 1'b1);
        expect_done("t7");
        checkv("t7_coef", coef_flat, pk(131071, -131072, -1, 0));

        // Totals
        tick();
        checkv("err_pulse_count", (T*W)'(err_cnt), (T*W)'(2));
        checkv("done_pulse_count", (T*W)'(done_cnt), (T*W)'(pushes));
        checkv("queue_drained", (T*W)'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
